// File: rtl/chip8_mem_defs.sv
// Shared constants for the CHIP-8 memory subsystem: memory geometry,
// port A requester indices and the arbiter state encoding.
package chip8_mem_defs;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    localparam int REQ_LOADER = 0;
    localparam int REQ_CPU    = 1;
    localparam int REQ_DRAW   = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ. Returns the winner one-hot and as an index.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic [PTR_W-1:0] winner_idx,
    output logic             found
);

    logic [NREQ-1:0][PTR_W-1:0] rot_idx;
    logic [NREQ-1:0]            rotated;

    // rot_idx[gi] = (ptr + gi) mod NREQ; the subtraction form stays in range
    // without needing a wider intermediate.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign rot_idx[gi] = (ptr >= PTR_W'(NREQ - gi)) ? ptr - PTR_W'(NREQ - gi)
                                                        : ptr + PTR_W'(gi);
        assign rotated[gi] = req[rot_idx[gi]];
    end

    always_comb begin
        found      = 1'b0;
        winner_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found      = 1'b1;
                winner_idx = rot_idx[k];
            end
        end
        winner = '0;
        if (found) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Port A arbiter for the CPU memory: round-robin between loader, CPU and
// draw engine with burst locking; read data returns one cycle after grant.
module cpu_mem_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = chip8_mem_defs::ADDR_W,
    parameter int DATA_W = chip8_mem_defs::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   mem_en,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    chip8_mem_defs::arb_state_e state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] owner_reg, owner_next;
    logic [NREQ-1:0]  rvalid_reg, rvalid_next;

    logic [NREQ-1:0]  pick_onehot;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_found;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_valid;

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .ptr        (ptr_reg),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        gnt        = '0;
        grant_idx  = owner_reg;

        if (reset) begin
            gnt = '0;
        end else if (state_reg == chip8_mem_defs::ST_LOCKED && lock[owner_reg]) begin
            // Burst in progress: only the owner may use the port, pointer frozen.
            gnt[owner_reg] = req[owner_reg];
        end else begin
            // Lock released (or idle): this cycle is arbitrated normally.
            state_next = chip8_mem_defs::ST_IDLE;
            if (pick_found) begin
                gnt       = pick_onehot;
                grant_idx = pick_idx;
                ptr_next  = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);
                if (lock[pick_idx]) begin
                    state_next = chip8_mem_defs::ST_LOCKED;
                    owner_next = pick_idx;
                end
            end
        end

        grant_valid = |gnt;
        mem_en      = grant_valid;
        mem_write   = grant_valid & we[grant_idx];
        mem_addr    = grant_valid ? addr_arr[grant_idx]  : '0;
        mem_wdata   = grant_valid ? wdata_arr[grant_idx] : '0;
        rvalid_next = mem_write ? '0 : gnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= chip8_mem_defs::ST_IDLE;
            ptr_reg    <= '0;
            owner_reg  <= '0;
            rvalid_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            rvalid_reg <= rvalid_next;
        end
    end

    assign rvalid = rvalid_reg;
    assign rdata  = mem_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed vector table, hand-written lock,
// fairness and reset sequences, then random traffic against a rule model.
module tb_cpu_mem_arbiter;
    import chip8_mem_defs::*;

    localparam int N = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req, we, lock, gnt, rvalid;
    logic [N*ADDR_W-1:0]  addr;
    logic [N*DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]    rdata, mem_rdata, mem_wdata;
    logic                 mem_en, mem_write;
    logic [ADDR_W-1:0]    mem_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.NREQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    function automatic logic [DATA_W-1:0] init_byte(input int a);
        if (a == 'h200) return 8'hA2;
        return DATA_W'(a * 37 + 11);
    endfunction

    // Synchronous memory port A: read-old-data, one cycle latency.
    logic [DATA_W-1:0] mem_model [1<<ADDR_W];
    logic [DATA_W-1:0] mem_q;
    bit                mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] <= init_byte(i);
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_write) mem_model[mem_addr] <= mem_wdata;
            mem_q <= mem_model[mem_addr];
        end
    end
    assign mem_rdata = mem_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*ADDR_W-1:0] pa(input logic [ADDR_W-1:0] a0, a1, a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [N*DATA_W-1:0] pd(input logic [DATA_W-1:0] d0, d1, d2);
        return {d2, d1, d0};
    endfunction

    // Reference model state: owner (-1 = none), pointer, expected read response.
    logic [DATA_W-1:0] ref_mem [1<<ADDR_W];
    int                m_owner, m_ptr;
    logic [N-1:0]      m_rv;
    logic [DATA_W-1:0] m_rdata;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_rv    = '0;
    endtask

    // Drive one cycle (called at posedge+1), check at negedge, return at posedge+1.
    task automatic do_cycle(input logic [N-1:0] r, w, l, input logic [N*ADDR_W-1:0] a,
                            input logic [N*DATA_W-1:0] d, output logic [N-1:0] g);
        int win;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic [N-1:0]      eg;
        logic [63:0]       exp_port;
        req = r; we = w; lock = l; addr = a; wdata = d;
        win = -1;
        if (m_owner >= 0 && l[m_owner]) begin
            if (r[m_owner]) win = m_owner;
        end else begin
            m_owner = -1;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) begin
                m_ptr = (win + 1) % N;
                if (l[win]) m_owner = win;
            end
        end
        eg = '0; ea = '0; ed = '0; exp_port = '0;
        if (win >= 0) begin
            eg[win]  = 1'b1;
            ea       = a[win*ADDR_W +: ADDR_W];
            ed       = d[win*DATA_W +: DATA_W];
            exp_port = 64'({1'b1, w[win], ea, ed});
        end
        @(negedge clk);
        g = gnt;
        check("gnt", 64'(gnt), 64'(eg));
        check("mem_port", 64'({mem_en, mem_write, mem_addr, mem_wdata}), exp_port);
        check("rvalid", 64'(rvalid), 64'(m_rv));
        if (m_rv != '0) check("rdata", 64'(rdata), 64'(m_rdata));
        m_rv = '0;
        if (win >= 0) begin
            if (w[win]) ref_mem[ea] = ed;
            else begin
                m_rv[win] = 1'b1;
                m_rdata   = ref_mem[ea];
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [N-1:0]        req, we, lock;
        logic [N*ADDR_W-1:0] addr;
        logic [N*DATA_W-1:0] wdata;
        logic [N-1:0]        gnt;
        logic [ADDR_W-1:0]   maddr;
        logic                mwrite;
        logic [DATA_W-1:0]   mwdata;
        logic [N-1:0]        rv;
        logic [DATA_W-1:0]   rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [N-1:0]        g;
        logic [N-1:0]        prev_g;
        logic [N-1:0]        r_req, r_we, r_lock;
        logic [N*ADDR_W-1:0] r_addr;
        logic [N*DATA_W-1:0] r_wdata;
        int cnt [N];
        int draw_cnt, cpu_cnt, order_bad;

        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = init_byte(i);
        model_reset();

        tbl[0] = '{3'b111, 3'b000, 3'b000, pa(12'h200, 12'h200, 12'h200), 24'h0, 3'b001, 12'h200, 1'b0, 8'h00, 3'b000, 8'h00};
        tbl[1] = '{3'b111, 3'b000, 3'b000, pa(12'h200, 12'h200, 12'h200), 24'h0, 3'b010, 12'h200, 1'b0, 8'h00, 3'b001, 8'hA2};
        tbl[2] = '{3'b111, 3'b000, 3'b000, pa(12'h200, 12'h200, 12'h200), 24'h0, 3'b100, 12'h200, 1'b0, 8'h00, 3'b010, 8'hA2};
        tbl[3] = '{3'b010, 3'b000, 3'b000, pa(12'h000, 12'h200, 12'h000), 24'h0, 3'b010, 12'h200, 1'b0, 8'h00, 3'b100, 8'hA2};
        tbl[4] = '{3'b000, 3'b000, 3'b000, pa(12'h000, 12'h000, 12'h000), 24'h0, 3'b000, 12'h000, 1'b0, 8'h00, 3'b010, 8'hA2};
        tbl[5] = '{3'b001, 3'b001, 3'b000, pa(12'h300, 12'h000, 12'h000), pd(8'h5A, 8'h00, 8'h00), 3'b001, 12'h300, 1'b1, 8'h5A, 3'b000, 8'h00};
        tbl[6] = '{3'b010, 3'b000, 3'b000, pa(12'h000, 12'h300, 12'h000), 24'h0, 3'b010, 12'h300, 1'b0, 8'h00, 3'b000, 8'h00};
        tbl[7] = '{3'b000, 3'b000, 3'b000, pa(12'h000, 12'h000, 12'h000), 24'h0, 3'b000, 12'h000, 1'b0, 8'h00, 3'b010, 8'h5A};

        // Reset held with every requester asking: nothing may be granted.
        reset = 1'b1; req = 3'b111; we = '0; lock = '0;
        addr = pa(12'h200, 12'h200, 12'h200); wdata = '0;
        repeat (2) begin
            @(negedge clk);
            check("reset_gnt", 64'(gnt), 64'(0));
            check("reset_mem_en", 64'(mem_en), 64'(0));
            check("reset_rvalid", 64'(rvalid), 64'(0));
        end
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req; we = tbl[i].we; lock = tbl[i].lock;
            addr = tbl[i].addr; wdata = tbl[i].wdata;
            @(negedge clk);
            check($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
            check($sformatf("tbl%0d_mem_en", i), 64'(mem_en), 64'(tbl[i].gnt != '0));
            check($sformatf("tbl%0d_mem", i), 64'({mem_write, mem_addr, mem_wdata}),
                  64'({tbl[i].mwrite, tbl[i].maddr, tbl[i].mwdata}));
            check($sformatf("tbl%0d_rvalid", i), 64'(rvalid), 64'(tbl[i].rv));
            if (tbl[i].rv != '0) check($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(tbl[i].rd));
            @(posedge clk); #1;
        end
        ref_mem[12'h300] = 8'h5A;

        reset = 1'b1; req = '0; lock = '0; we = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Draw engine bursts 5 locked reads while the CPU keeps asking.
        do_cycle(3'b010, 3'b000, 3'b000, pa(12'h0, 12'h201, 12'h0), '0, g);
        draw_cnt = 0; cpu_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            do_cycle(3'b110, 3'b000, N'(1) << REQ_DRAW,
                     pa(12'h0, 12'h201, ADDR_W'(12'h050 + k)), '0, g);
            if (g == (N'(1) << REQ_DRAW)) draw_cnt++;
            if (g[REQ_CPU]) cpu_cnt++;
        end
        check("burst_draw_grants", 64'(draw_cnt), 64'(5));
        check("burst_cpu_blocked", 64'(cpu_cnt), 64'(0));
        do_cycle(3'b010, 3'b000, 3'b000, pa(12'h0, 12'h201, 12'h0), '0, g);
        check("cpu_after_burst", 64'(g), 64'(N'(1) << REQ_CPU));

        // Nine cycles of full contention without lock.
        do_cycle('0, '0, '0, '0, '0, g);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        order_bad = 0; prev_g = '0;
        for (int k = 0; k < 9; k++) begin
            do_cycle(3'b111, 3'b000, 3'b000, pa(12'h010, 12'h011, 12'h012), '0, g);
            for (int i = 0; i < N; i++) if (g[i]) cnt[i]++;
            if (k > 0 && g != {prev_g[N-2:0], prev_g[N-1]}) order_bad++;
            prev_g = g;
        end
        check("fair_order", 64'(order_bad), 64'(0));
        check("fair_loader", 64'(cnt[REQ_LOADER]), 64'(3));
        check("fair_cpu", 64'(cnt[REQ_CPU]), 64'(3));
        check("fair_draw", 64'(cnt[REQ_DRAW]), 64'(3));

        // Random traffic: commands held until granted, random locks.
        r_req = '0; r_we = '0; r_lock = '0; r_addr = '0; r_wdata = '0; g = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_req[i] || g[i]) begin
                    r_req[i] = ($urandom_range(0, 9) < 6);
                    r_we[i]  = ($urandom_range(0, 2) == 0);
                    r_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 15));
                    r_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
                r_lock[i] = ($urandom_range(0, 3) == 0);
            end
            do_cycle(r_req, r_we, r_lock, r_addr, r_wdata, g);
        end
        do_cycle('0, '0, '0, '0, '0, g);

        // Reset right after a locked read grant drops the pending rvalid.
        req = N'(1) << REQ_CPU; we = '0; lock = N'(1) << REQ_CPU;
        addr = pa(12'h0, 12'h123, 12'h0); wdata = '0;
        @(negedge clk);
        check("rst_read_gnt", 64'(gnt), 64'(N'(1) << REQ_CPU));
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_rvalid_edge", 64'(rvalid), 64'(0));
        req = 3'b111;
        @(negedge clk);
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_gnt", 64'(gnt), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        do_cycle(3'b111, 3'b000, N'(1) << REQ_CPU, pa(12'h020, 12'h021, 12'h022), '0, g);
        check("post_reset_ptr_idle", 64'(g), 64'(N'(1) << REQ_LOADER));
        do_cycle('0, '0, '0, '0, '0, g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares the single read/write port (port A) of the 4096×8 CPU memory between several requesters: the CPU fetch/execute unit, the sprite draw engine and the program loader. It grants one access per cycle, uses round-robin fairness with an optional lock for multi-byte bursts (FX55/FX65, sprite rows), and returns read data one cycle after grant. It sits between the requesters and the memory's port A; port B (video) is untouched.

## Interface
- NREQ, 3: number of requesters; index 0 = loader, 1 = CPU, 2 = draw engine.
- ADDR_W, 12: memory address width.
- DATA_W, 8: memory data width.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester access request; held with its command until granted.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read).
- lock  in  NREQ  per-requester burst lock; keeps the grant while high.
- addr  in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*DATA_W  packed write data, same packing.
- gnt  out  NREQ  one-hot; gnt[i]=1 means requester i's command is issued to memory this cycle.
- rvalid  out  NREQ  one-hot; read data for requester i is on rdata this cycle.
- rdata  out  DATA_W  read data, shared by all requesters.
- mem_en  out  1  to memory a_en.
- mem_write  out  1  to memory a_write.
- mem_addr  out  ADDR_W  to memory a_addr.
- mem_wdata  out  DATA_W  to memory a_in.

## Operation
- States: IDLE (no owner) and LOCKED (owner register holds index o).
- IDLE: if any req bit is set, the winner is the first set bit at or after the round-robin pointer ptr, wrapping modulo NREQ. gnt[winner]=1, mem_* driven from the winner's fields, and ptr ← (winner+1) mod NREQ. If lock[winner]=1, go to LOCKED with o=winner.
- LOCKED: only requester o can win. If req[o]=1, grant it. Others wait even if their req is high. Return to IDLE on the first cycle lock[o]=0; that cycle is arbitrated as in IDLE, so o may still win it fairly. ptr does not advance while LOCKED.
- No request: gnt=0, mem_en=0, and mem_write/mem_addr/mem_wdata are 0.
- Reads: when a read is granted in cycle N, rvalid[winner]=1 in cycle N+1 and rdata = memory a_out (passed straight through, no extra register).
- Writes: never produce rvalid. The memory returns its old contents; rdata is ignored.
- A requester must not change addr/we/wdata while req=1 and gnt=0. It may drop req only after gnt.
- A requester may issue back-to-back accesses, one per cycle, if it wins every cycle (locked, or sole requester).
- Reset values: state=IDLE, ptr=0, o=0, rvalid=0. While reset is high, gnt=0 and mem_en=0 regardless of req.
- Reset mid-operation: a pending rvalid is dropped. Requesters re-issue after reset.

## Timing
- Arbitration is combinational from req, lock, state and ptr to gnt/mem_*: zero-cycle grant latency.
- Read latency from the grant cycle to rvalid is exactly 1 cycle. Throughput is 1 access per cycle.
- Registered state: state, o, ptr, rvalid_q[NREQ]. rvalid = rvalid_q.
- Simultaneous requests: pure round-robin. No requester waits more than NREQ-1 grants, excluding time spent behind a lock.
- Lock and req both dropping in the same cycle in LOCKED: go to IDLE with no grant from o that cycle; others may win it.

## Structure
- Shared package/include (chip8_mem_defs): ADDR_W=12, DATA_W=8, requester index constants REQ_LOADER=0, REQ_CPU=1, REQ_DRAW=2, and state encodings ST_IDLE/ST_LOCKED.
- One sub-module: rr_pick. It is combinational: inputs req vector and ptr; outputs one-hot winner and its index. The top holds the FSM, ptr, the owner register and the rvalid pipeline.

## Test plan
- Reset with req=3'b111 held → gnt=0 and mem_en=0 during reset; first cycle after release gnt=3'b001 (ptr=0), then 3'b010, then 3'b100.
- CPU reads 0x200 (memory preloaded 0xA2) → gnt[1] in cycle N with mem_addr=0x200 and mem_write=0; rvalid=3'b010 with rdata=0xA2 in N+1.
- Loader writes 0x5A to 0x300, then the CPU reads 0x300 → CPU rdata=0x5A. The write produces no rvalid.
- Draw engine locks for 5 reads (0x050–0x054) while the CPU requests continuously → 5 consecutive gnt[2]. The CPU is granted on the cycle lock[2] drops or the next one, never during the burst.
- All three requesting for 9 cycles with no lock → each requester granted exactly 3 times, in strict order.
- Reset asserted the cycle after a read grant → rvalid stays 0. After release: state=IDLE, ptr=0.
